// File: rtl/dds_pkg.sv
// Shared widths, quadrant encoding and sine-table generation for the multi-phase DDS.
// Table entries are computed at elaboration; nothing here is clocked.
package dds_pkg;

   localparam int DEF_N_CH    = 3;
   localparam int DEF_PHASE_W = 32;
   localparam int DEF_OUT_W   = 16;
   localparam int DEF_LUT_AW  = 10;

   localparam real PI = 3.14159265358979323846;

   typedef enum logic [1:0] {
      QUAD_0 = 2'd0,
      QUAD_1 = 2'd1,
      QUAD_2 = 2'd2,
      QUAD_3 = 2'd3
   } quad_t;

   function automatic int amp(input int out_w);
      return (1 << (out_w - 1)) - 1;
   endfunction

   // Entry k of the quarter-wave table; k == 2^lut_aw yields the full amplitude.
   function automatic int lut_entry(input int k, input int out_w, input int lut_aw);
      real r;
      r = real'(amp(out_w)) * $sin(PI / 2.0 * real'(k) / real'(1 << lut_aw));
      return $rtoi(r + 0.5);
   endfunction

endpackage

// File: rtl/dds_quarter_lut.sv
// Quarter-wave sine lookup with registered read (S3) and registered sign restore (S4).
// Latency 2 clocks; each stage only advances when its enable (valid) is high, else holds.
module dds_quarter_lut
   import dds_pkg::*;
#(
   parameter int LUT_AW = DEF_LUT_AW,
   parameter int OUT_W  = DEF_OUT_W
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_rd_en,
   input  logic                    i_out_en,
   input  logic [LUT_AW:0]         i_addr,
   input  logic                    i_neg,
   output logic signed [OUT_W-1:0] o_sample
);

   localparam int DEPTH = (1 << LUT_AW) + 1;

   logic [OUT_W-1:0] w_rom [DEPTH];
   logic [OUT_W-1:0] r_mag;
   logic             r_neg;

   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      assign w_rom[k] = OUT_W'(lut_entry(k, OUT_W, LUT_AW));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mag    <= '0;
         r_neg    <= 1'b0;
         o_sample <= '0;
      end else begin
         if (i_rd_en) begin
            r_mag <= w_rom[i_addr];
            r_neg <= i_neg;
         end
         if (i_out_en) begin
            o_sample <= r_neg ? -$signed(r_mag) : $signed(r_mag);
         end
      end
   end

endmodule

// File: rtl/dds_multi_phase.sv
// N-channel phase-coherent DDS: one shared accumulator, per-channel offset, quarter-wave sine.
// Latency 4 clocks acc->out; no backpressure, valid bubbles follow enable and out holds during them.
module dds_multi_phase
   import dds_pkg::*;
#(
   parameter int N_CH    = DEF_N_CH,
   parameter int PHASE_W = DEF_PHASE_W,
   parameter int OUT_W   = DEF_OUT_W,
   parameter int LUT_AW  = DEF_LUT_AW
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_frq_valid,
   input  logic [PHASE_W-1:0]        i_frq,
   input  logic                      i_phase_valid,
   input  logic [N_CH*PHASE_W-1:0]   i_phase_offset,
   input  logic                      i_sync,
   input  logic                      i_enable,
   output logic                      o_out_valid,
   output logic [N_CH*OUT_W-1:0]     o_out
);

   logic [PHASE_W-1:0]              r_acc;
   logic [PHASE_W-1:0]              r_frq;
   logic                            r_loaded;
   logic [N_CH-1:0][PHASE_W-1:0]    r_off;
   logic [N_CH-1:0][PHASE_W-1:0]    r_p;
   logic [N_CH-1:0][LUT_AW:0]       r_addr;
   logic [N_CH-1:0]                 r_neg;
   logic [3:0]                      r_vld;

   logic                            w_run;
   logic [N_CH-1:0][LUT_AW:0]       w_fold;
   logic [N_CH-1:0]                 w_neg;
   logic [N_CH-1:0][OUT_W-1:0]      w_samp;

   assign w_run = i_enable & r_loaded;
   assign o_out = w_samp;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc       <= '0;
         r_frq       <= '0;
         r_loaded    <= 1'b0;
         r_off       <= '0;
         r_p         <= '0;
         r_addr      <= '0;
         r_neg       <= '0;
         r_vld       <= '0;
         o_out_valid <= 1'b0;
      end else begin
         if (i_frq_valid) begin
            r_frq    <= i_frq;
            r_loaded <= 1'b1;
         end
         if (i_phase_valid) begin
            r_off <= i_phase_offset;
         end
         // sync wins over run so a simultaneous frq load starts cleanly from zero
         if (i_sync) begin
            r_acc <= '0;
         end else if (w_run) begin
            r_acc <= r_acc + r_frq;
         end
         r_vld       <= {r_vld[2:0], w_run};
         o_out_valid <= r_vld[3];
         for (int c = 0; c < N_CH; c++) begin
            if (r_vld[0]) begin
               r_p[c] <= r_acc + r_off[c];
            end
            if (r_vld[1]) begin
               r_addr[c] <= w_fold[c];
               r_neg[c]  <= w_neg[c];
            end
         end
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      quad_t             w_q;
      logic [LUT_AW-1:0] w_a;
      logic              w_unused_lo;

      assign w_q  = quad_t'(r_p[c][PHASE_W-1 -: 2]);
      assign w_a  = r_p[c][PHASE_W-3 -: LUT_AW];
      // Quadrants 1 and 3 run the table backwards; 2 and 3 are the negative half-cycle.
      assign w_fold[c] = (w_q == QUAD_1 || w_q == QUAD_3) ?
                         ({1'b1, {LUT_AW{1'b0}}} - {1'b0, w_a}) : {1'b0, w_a};
      assign w_neg[c]  = (w_q == QUAD_2 || w_q == QUAD_3);
      assign w_unused_lo = ^r_p[c][PHASE_W-LUT_AW-3:0];

      dds_quarter_lut #(
         .LUT_AW (LUT_AW),
         .OUT_W  (OUT_W)
      ) u_lut (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_rd_en  (r_vld[2]),
         .i_out_en (r_vld[3]),
         .i_addr   (r_addr[c]),
         .i_neg    (r_neg[c]),
         .o_sample (w_samp[c])
      );
   end

endmodule

// File: tb/tb_dds_multi_phase.sv
// Directed bench for dds_multi_phase: reset, quarter steps, offsets, runtime updates, gating, wrap.
module tb_dds_multi_phase;

   localparam real PI_R = 3.14159265358979323846;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frq_valid;
   logic [31:0] frq;
   logic        phase_valid;
   logic [95:0] phase_offset;
   logic        sync;
   logic        enable;
   logic        out_valid;
   logic [47:0] out;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   dds_multi_phase u_dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_frq_valid    (frq_valid),
      .i_frq          (frq),
      .i_phase_valid  (phase_valid),
      .i_phase_offset (phase_offset),
      .i_sync         (sync),
      .i_enable       (enable),
      .o_out_valid    (out_valid),
      .o_out          (out)
   );

   function automatic logic signed [15:0] golden(input logic [31:0] p);
      logic [11:0] idx;
      logic [10:0] fa;
      real         r;
      int          mag;
      idx = p[31:20];
      fa  = idx[10] ? (11'd1024 - {1'b0, idx[9:0]}) : {1'b0, idx[9:0]};
      r   = 32767.0 * $sin(PI_R / 2.0 * real'(fa) / 1024.0);
      mag = $rtoi(r + 0.5);
      golden = idx[11] ? 16'(-mag) : 16'(mag);
   endfunction

   function automatic logic signed [15:0] ch_out(input int c);
      ch_out = out[c*16 +: 16];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      frq_valid    = 1'b0;
      frq          = '0;
      phase_valid  = 1'b0;
      phase_offset = '0;
      sync         = 1'b0;
      enable       = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Loads frq/offsets, then starts with sync+enable; returns after the sync edge (acc = 0, valid).
   task automatic start_run(input logic [31:0] f, input logic [95:0] offs);
      frq          = f;
      frq_valid    = 1'b1;
      phase_offset = offs;
      phase_valid  = 1'b1;
      tick();
      frq_valid   = 1'b0;
      phase_valid = 1'b0;
      enable      = 1'b1;
      sync        = 1'b1;
      tick();
      sync = 1'b0;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      frq_valid    = 1'b0;
      frq          = '0;
      phase_valid  = 1'b0;
      phase_offset = '0;
      sync         = 1'b0;
      enable       = 1'b1;
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || out !== 48'd0) begin
         tests_failed++;
         $display("FAIL reset_state: out_valid=%b out=%h, want 0 and 0", out_valid, out);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         tests_run++;
         if (out_valid !== 1'b0 || out !== 48'd0) begin
            tests_failed++;
            $display("FAIL idle_no_frq cyc %0d: out_valid=%b out=%h, want 0 and 0", i, out_valid, out);
         end
      end
   endtask

   task automatic test_quarter();
      logic signed [15:0] qtab [4];
      qtab = '{16'sd0, 16'sd32767, 16'sd0, -16'sd32767};
      do_reset();
      start_run(32'h4000_0000, 96'd0);
      for (int j = 1; j <= 3; j++) begin
         tick();
         tests_run++;
         if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL quarter_latency edge %0d: out_valid=%b, want 0", j, out_valid);
         end
      end
      for (int k = 0; k < 12; k++) begin
         tick();
         tests_run++;
         if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL quarter_valid sample %0d: out_valid=%b, want 1", k, out_valid);
         end
         for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (ch_out(c) !== qtab[k % 4]) begin
               tests_failed++;
               $display("FAIL quarter_seq s%0d ch%0d: got %0d want %0d", k, c, ch_out(c), qtab[k % 4]);
            end
         end
      end
   endtask

   task automatic test_offsets();
      logic [31:0]        a;
      logic [31:0]        offs [3];
      logic signed [15:0] exp_s;
      offs = '{32'd0, 32'd13421773, 32'd93952410};
      do_reset();
      start_run(32'd5000000, {offs[2], offs[1], offs[0]});
      a = '0;
      repeat (3) tick();
      for (int k = 0; k < 10000; k++) begin
         tick();
         tests_run++;
         if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL offsets_valid sample %0d: out_valid=%b, want 1", k, out_valid);
         end
         if (k == 0) begin
            tests_run++;
            if (ch_out(0) !== 16'sd0 || ch_out(1) !== 16'sd603 || ch_out(2) !== 16'sd4460) begin
               tests_failed++;
               $display("FAIL offsets_first: got %0d %0d %0d want 0 603 4460", ch_out(0), ch_out(1), ch_out(2));
            end
         end
         for (int c = 0; c < 3; c++) begin
            exp_s = golden(a + offs[c]);
            tests_run++;
            if (ch_out(c) !== exp_s) begin
               tests_failed++;
               $display("FAIL offsets s%0d ch%0d: got %0d want %0d", k, c, ch_out(c), exp_s);
            end
         end
         a = a + 32'd5000000;
      end
   endtask

   task automatic test_runtime_update();
      logic [31:0]        ah [0:40];
      logic [31:0]        old_off [3];
      logic [31:0]        new_off [3];
      logic [31:0]        o;
      logic signed [15:0] exp_s;
      int                 s;
      old_off = '{32'd0, 32'd0, 32'd0};
      new_off = '{32'h4000_0000, 32'd0, 32'h8000_0000};
      do_reset();
      start_run(32'h4000_0000, 96'd0);
      ah[0] = '0;
      for (int j = 1; j <= 36; j++) begin
         frq_valid   = (j == 6);
         if (j == 6) frq = 32'h2000_0000;
         phase_valid = (j == 14);
         if (j == 14) phase_offset = {new_off[2], new_off[1], new_off[0]};
         tick();
         frq_valid   = 1'b0;
         phase_valid = 1'b0;
         ah[j] = ah[j-1] + ((j <= 6) ? 32'h4000_0000 : 32'h2000_0000);
         if (j >= 4) begin
            s = j - 4;
            for (int c = 0; c < 3; c++) begin
               o     = (s >= 14) ? new_off[c] : old_off[c];
               exp_s = golden(ah[s] + o);
               tests_run++;
               if (out_valid !== 1'b1 || ch_out(c) !== exp_s) begin
                  tests_failed++;
                  $display("FAIL runtime_update s%0d ch%0d: vld=%b got %0d want 1 %0d", s, c, out_valid, ch_out(c), exp_s);
               end
            end
         end
      end
   endtask

   task automatic test_enable_gating();
      logic [31:0]        ah [0:44];
      logic               vh [0:44];
      logic [31:0]        offs [3];
      logic signed [15:0] held [3];
      logic signed [15:0] exp_s;
      logic [31:0]        a;
      int                 s;
      offs = '{32'd0, 32'h4000_0000, 32'h8000_0000};
      do_reset();
      start_run(32'h1000_0000, {offs[2], offs[1], offs[0]});
      a = '0;
      ah[0] = '0;
      vh[0] = 1'b1;
      held = '{16'sd0, 16'sd0, 16'sd0};
      for (int j = 1; j <= 40; j++) begin
         enable = !(j >= 10 && j <= 16);
         tick();
         if (enable) a = a + 32'h1000_0000;
         ah[j] = a;
         vh[j] = enable;
         if (j >= 4) begin
            s = j - 4;
            tests_run++;
            if (out_valid !== vh[s]) begin
               tests_failed++;
               $display("FAIL gating_valid edge %0d: out_valid=%b want %b", j, out_valid, vh[s]);
            end
            for (int c = 0; c < 3; c++) begin
               if (vh[s]) held[c] = golden(ah[s] + offs[c]);
               exp_s = held[c];
               tests_run++;
               if (ch_out(c) !== exp_s) begin
                  tests_failed++;
                  $display("FAIL gating_out edge %0d ch%0d: got %0d want %0d", j, c, ch_out(c), exp_s);
               end
            end
         end
      end
      enable = 1'b1;
   endtask

   task automatic test_wrap_sync();
      logic [31:0]        ah [0:34];
      logic [31:0]        fm;
      logic signed [15:0] exp_s;
      int                 s;
      do_reset();
      start_run(32'h4000_0000, 96'd0);
      fm = 32'h4000_0000;
      ah[0] = '0;
      for (int j = 1; j <= 30; j++) begin
         sync      = (j == 6);
         frq_valid = (j == 6);
         if (j == 6) frq = 32'hFFFF_FFFF;
         tick();
         sync      = 1'b0;
         frq_valid = 1'b0;
         ah[j] = (j == 6) ? 32'd0 : ah[j-1] + fm;
         if (j == 6) fm = 32'hFFFF_FFFF;
         if (j >= 4) begin
            s = j - 4;
            for (int c = 0; c < 3; c++) begin
               exp_s = golden(ah[s]);
               tests_run++;
               if (out_valid !== 1'b1 || ch_out(c) !== exp_s) begin
                  tests_failed++;
                  $display("FAIL wrap s%0d ch%0d: vld=%b got %0d want 1 %0d", s, c, out_valid, ch_out(c), exp_s);
               end
            end
            if (s == 7) begin
               tests_run++;
               if (ch_out(0) !== -16'sd50) begin
                  tests_failed++;
                  $display("FAIL wrap_first_decrement: got %0d want -50", ch_out(0));
               end
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      start_run(32'h4000_0000, 96'd0);
      repeat (8) tick();
      tests_run++;
      if (out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_reset_pre: out_valid=%b want 1", out_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || out !== 48'd0) begin
         tests_failed++;
         $display("FAIL mid_reset_immediate: out_valid=%b out=%h want 0 and 0", out_valid, out);
      end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         tests_run++;
         if (out_valid !== 1'b0 || out !== 48'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_after cyc %0d: out_valid=%b out=%h want 0 and 0", i, out_valid, out);
         end
      end
   endtask

   initial begin
      test_reset();
      test_quarter();
      test_offsets();
      test_runtime_update();
      test_enable_gating();
      test_wrap_sync();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
